// File: rtl/param_micro_core_pkg.sv
// Shared opcodes, FSM state encoding and instruction-field helpers for param_micro_core.
package param_micro_core_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_CLR  = 4'h3;
  localparam logic [3:0] OP_ADDA = 4'h4;
  localparam logic [3:0] OP_ADDB = 4'h5;
  localparam logic [3:0] OP_SUBA = 4'h6;
  localparam logic [3:0] OP_SUBB = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_AND  = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
  localparam logic [3:0] OP_OUT  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_JF   = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    ST_HALT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_OUTWAIT
  } state_t;

  // The opcode sits directly above the branch-target field.
  function automatic int op_lsb(input int pc_w);
    return pc_w;
  endfunction

endpackage

// File: rtl/param_micro_core_if.sv
// Bus bundle for param_micro_core: instruction port, switches, output handshake and debug view.
interface param_micro_core_if #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 5
);
  localparam int ACC_W = 2 * DATA_W;
  localparam int IW    = 4 + PC_W;

  logic              start;
  logic [DATA_W-1:0] sw_a;
  logic [DATA_W-1:0] sw_b;
  logic [PC_W-1:0]   instr_addr;
  logic [IW-1:0]     instr_data;
  logic [ACC_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [ACC_W-1:0]  acc;
  logic              flag;
  logic [PC_W-1:0]   pc;
  logic [IW-1:0]     ir;
  logic              halted;

  modport master (
    output start, sw_a, sw_b, instr_data, out_ready,
    input  instr_addr, out_data, out_valid, reg_a, reg_b, acc, flag, pc, ir, halted
  );

  modport slave (
    input  start, sw_a, sw_b, instr_data, out_ready,
    output instr_addr, out_data, out_valid, reg_a, reg_b, acc, flag, pc, ir, halted
  );

endinterface

// File: rtl/param_micro_core_alu.sv
// Combinational accumulator datapath; multiplier present only with PARAM_MICRO_CORE_MUL_EN.
module param_micro_core_alu
  import param_micro_core_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [3:0]          op,
  input  logic [DATA_W-1:0]   reg_a,
  input  logic [DATA_W-1:0]   reg_b,
  input  logic [2*DATA_W-1:0] acc_in,
  input  logic                flag_in,
  output logic [2*DATA_W-1:0] acc_out,
  output logic                flag_out
);
  localparam int ACC_W = 2 * DATA_W;

  logic [ACC_W-1:0] operand;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   diff;
`ifdef PARAM_MICRO_CORE_MUL_EN
  logic [ACC_W-1:0] product;

  assign product = {{DATA_W{1'b0}}, reg_a} * {{DATA_W{1'b0}}, reg_b};
`endif

  // Opcode bit 0 picks reg_b for the B-variants of add and subtract.
  assign operand = {{DATA_W{1'b0}}, (op[0] ? reg_b : reg_a)};
  assign sum     = {1'b0, acc_in} + {1'b0, operand};
  assign diff    = {1'b0, acc_in} - {1'b0, operand};

  always_comb begin
    acc_out  = acc_in;
    flag_out = flag_in;
    case (op)
      OP_CLR: begin
        acc_out  = '0;
        flag_out = 1'b0;
      end
      OP_ADDA, OP_ADDB: begin
        acc_out  = sum[ACC_W-1:0];
        flag_out = sum[ACC_W];
      end
      OP_SUBA, OP_SUBB: begin
        acc_out  = diff[ACC_W-1:0];
        flag_out = diff[ACC_W];
      end
      OP_SHL: begin
        acc_out  = {acc_in[ACC_W-2:0], 1'b0};
        flag_out = acc_in[ACC_W-1];
      end
      OP_SHR: begin
        acc_out  = {1'b0, acc_in[ACC_W-1:1]};
        flag_out = acc_in[0];
      end
      OP_AND: acc_out = {{DATA_W{1'b0}}, reg_a & reg_b};
`ifdef PARAM_MICRO_CORE_MUL_EN
      OP_MUL: acc_out = product;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/param_micro_core.sv
// Parametrised micro core: FSM, pc/ir, operand registers and output handshake.
// Opcode B multiplies only when PARAM_MICRO_CORE_MUL_EN is defined; otherwise it is a NOP.
module param_micro_core
  import param_micro_core_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PC_W   = 5
) (
  input logic              clk,
  input logic              reset,
  param_micro_core_if.slave bus
);
  localparam int ACC_W  = 2 * DATA_W;
  localparam int IW     = 4 + PC_W;
  localparam int OP_LSB = op_lsb(PC_W);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   instr_addr_q, instr_addr_d;
  logic [IW-1:0]     ir_q, ir_d;
  logic [DATA_W-1:0] reg_a_q, reg_a_d;
  logic [DATA_W-1:0] reg_b_q, reg_b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              flag_q, flag_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [3:0]        opcode;
  logic [PC_W-1:0]   target;
  logic [PC_W-1:0]   pc_inc;
  logic [ACC_W-1:0]  alu_acc;
  logic              alu_flag;

  assign opcode = ir_q[OP_LSB +: 4];
  assign target = ir_q[PC_W-1:0];
  assign pc_inc = pc_q + PC_W'(1);

  param_micro_core_alu #(.DATA_W(DATA_W)) u_alu (
    .op       (opcode),
    .reg_a    (reg_a_q),
    .reg_b    (reg_b_q),
    .acc_in   (acc_q),
    .flag_in  (flag_q),
    .acc_out  (alu_acc),
    .flag_out (alu_flag)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_addr_d = instr_addr_q;
    ir_d         = ir_q;
    reg_a_d      = reg_a_q;
    reg_b_d      = reg_b_q;
    acc_d        = acc_q;
    flag_d       = flag_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    case (state_q)
      ST_HALT:   if (bus.start) state_d = ST_FETCH;
      ST_FETCH: begin
        instr_addr_d = pc_q;
        state_d      = ST_DECODE;
      end
      ST_DECODE: begin
        ir_d    = bus.instr_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // HLT also advances pc so a later start resumes after it.
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        acc_d   = alu_acc;
        flag_d  = alu_flag;
        case (opcode)
          OP_LDA: reg_a_d = bus.sw_a;
          OP_LDB: reg_b_d = bus.sw_b;
          OP_OUT: begin
            out_data_d  = acc_q;
            out_valid_d = 1'b1;
            state_d     = ST_OUTWAIT;
          end
          OP_JMP: pc_d = target;
          OP_JF:  if (flag_q) pc_d = target;
          OP_HLT: state_d = ST_HALT;
          default: ;
        endcase
      end
      ST_OUTWAIT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_FETCH;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_HALT;
      pc_q         <= '0;
      instr_addr_q <= '0;
      ir_q         <= '0;
      reg_a_q      <= '0;
      reg_b_q      <= '0;
      acc_q        <= '0;
      flag_q       <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_addr_q <= instr_addr_d;
      ir_q         <= ir_d;
      reg_a_q      <= reg_a_d;
      reg_b_q      <= reg_b_d;
      acc_q        <= acc_d;
      flag_q       <= flag_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.instr_addr = instr_addr_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.reg_a      = reg_a_q;
  assign bus.reg_b      = reg_b_q;
  assign bus.acc        = acc_q;
  assign bus.flag       = flag_q;
  assign bus.pc         = pc_q;
  assign bus.ir         = ir_q;
  assign bus.halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_param_micro_core.sv
// Directed bench for param_micro_core: instruction-level model checked every cycle plus literal spot checks.
module tb_param_micro_core;
  import param_micro_core_pkg::*;

  localparam int DATA_W = 4;
  localparam int PC_W   = 5;
  localparam int ACC_W  = 2 * DATA_W;
  localparam int IW     = 4 + PC_W;
  localparam int DEPTH  = 1 << PC_W;

  logic clk;
  logic reset;
  logic [IW-1:0] mem [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  param_micro_core_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  param_micro_core #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.instr_data = mem[bus.instr_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction-level model: each instruction spends fetch/decode/execute edges, OUT waits for ready.
  bit              m_init = 1'b0;
  bit              m_halted, m_outwait;
  int              m_cnt;
  logic [PC_W-1:0] m_pc, m_addr;
  logic [IW-1:0]   m_ir;
  longint          m_a, m_b, m_acc, m_out;
  bit              m_flag, m_valid;

  task automatic m_execute();
    logic [3:0] op;
    longint     modv;
    longint     r;
    op   = m_ir[IW-1 -: 4];
    modv = longint'(1) << ACC_W;
    r    = op[0] ? m_b : m_a;
    m_pc = PC_W'((int'(m_pc) + 1) % DEPTH);
    case (op)
      OP_LDA:  m_a = longint'(bus.sw_a);
      OP_LDB:  m_b = longint'(bus.sw_b);
      OP_CLR:  begin m_acc = 0; m_flag = 1'b0; end
      OP_ADDA, OP_ADDB: begin
        m_flag = (m_acc + r) >= modv;
        m_acc  = (m_acc + r) % modv;
      end
      OP_SUBA, OP_SUBB: begin
        m_flag = m_acc < r;
        m_acc  = (m_acc - r + modv) % modv;
      end
      OP_SHL:  begin m_flag = m_acc >= (modv / 2); m_acc = (m_acc * 2) % modv; end
      OP_SHR:  begin m_flag = (m_acc % 2) == 1; m_acc = m_acc / 2; end
      OP_AND:  m_acc = m_a & m_b;
`ifdef PARAM_MICRO_CORE_MUL_EN
      OP_MUL:  m_acc = m_a * m_b;
`endif
      OP_OUT:  begin m_out = m_acc; m_valid = 1'b1; m_outwait = 1'b1; end
      OP_JMP:  m_pc = m_ir[PC_W-1:0];
      OP_JF:   if (m_flag) m_pc = m_ir[PC_W-1:0];
      OP_HLT:  m_halted = 1'b1;
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_init = 1'b1; m_halted = 1'b1; m_outwait = 1'b0; m_cnt = 0;
        m_pc = '0; m_addr = '0; m_ir = '0;
        m_a = 0; m_b = 0; m_acc = 0; m_out = 0; m_flag = 1'b0; m_valid = 1'b0;
      end else if (m_halted) begin
        if (bus.start) begin m_halted = 1'b0; m_cnt = 0; end
      end else if (m_outwait) begin
        if (bus.out_ready) begin m_outwait = 1'b0; m_valid = 1'b0; m_cnt = 0; end
      end else begin
        m_cnt++;
        if (m_cnt == 1) m_addr = m_pc;
        else if (m_cnt == 2) m_ir = mem[m_addr];
        else begin m_cnt = 0; m_execute(); end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        check("m_halted", 64'(bus.halted), 64'(m_halted));
        check("m_pc", 64'(bus.pc), 64'(m_pc));
        check("m_instr_addr", 64'(bus.instr_addr), 64'(m_addr));
        check("m_ir", 64'(bus.ir), 64'(m_ir));
        check("m_reg_a", 64'(bus.reg_a), 64'(m_a));
        check("m_reg_b", 64'(bus.reg_b), 64'(m_b));
        check("m_acc", 64'(bus.acc), 64'(m_acc));
        check("m_flag", 64'(bus.flag), 64'(m_flag));
        check("m_out_valid", 64'(bus.out_valid), 64'(m_valid));
        check("m_out_data", 64'(bus.out_data), 64'(m_out));
      end
    end
  end

  function automatic logic [IW-1:0] ins(input logic [3:0] op, input int tgt);
    return {op, PC_W'(tgt)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = ins(OP_HLT, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_halted(input string name);
    int n = 0;
    while (!bus.halted && n < 500) begin @(negedge clk); n++; end
    if (!bus.halted) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=running required=halted", name);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.out_valid && n < 500) begin @(negedge clk); n++; end
    if (!bus.out_valid) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=0 required=out_valid", name);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_halted"}, 64'(bus.halted), 64'd1);
    check({tag, "_pc"}, 64'(bus.pc), 64'd0);
    check({tag, "_ir"}, 64'(bus.ir), 64'd0);
    check({tag, "_addr"}, 64'(bus.instr_addr), 64'd0);
    check({tag, "_regs"}, 64'({bus.reg_a, bus.reg_b}), 64'd0);
    check({tag, "_acc"}, 64'(bus.acc), 64'd0);
    check({tag, "_flag"}, 64'(bus.flag), 64'd0);
    check({tag, "_out"}, 64'({bus.out_valid, bus.out_data}), 64'd0);
  endtask

  task automatic load_sum_prog();
    clear_mem();
    mem[0] = ins(OP_LDA, 0);
    mem[1] = ins(OP_LDB, 0);
    mem[2] = ins(OP_ADDA, 0);
    mem[3] = ins(OP_ADDB, 0);
    mem[4] = ins(OP_OUT, 0);
    mem[5] = ins(OP_HLT, 0);
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    bus.sw_a = '0;
    bus.sw_b = '0;
    bus.out_ready = 1'b0;
    clear_mem();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_zero("reset");

    // Sum program with output stall.
    load_sum_prog();
    bus.sw_a = 4'd9;
    bus.sw_b = 4'd3;
    pulse_start();
    wait_valid("sum");
    check("sum_out_data", 64'(bus.out_data), 64'h0C);
    check("sum_flag", 64'(bus.flag), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_data", 64'(bus.out_data), 64'h0C);
      check("stall_addr", 64'(bus.instr_addr), 64'd4);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("handshake_valid", 64'(bus.out_valid), 64'd0);
    wait_halted("sum");
    check("sum_halted", 64'(bus.halted), 64'd1);
    check("sum_pc", 64'(bus.pc), 64'd6);

    // Borrow then conditional branch, taken and not taken.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      clear_mem();
      mem[0] = ins(OP_CLR, 0);
      mem[1] = ins(OP_LDB, 0);
      mem[2] = ins(OP_SUBB, 0);
      mem[3] = ins(OP_JF, 5);
      bus.sw_b = (k == 0) ? 4'd1 : 4'd0;
      pulse_start();
      wait_halted("jf");
      check("jf_acc", 64'(bus.acc), (k == 0) ? 64'hFF : 64'h00);
      check("jf_flag", 64'(bus.flag), (k == 0) ? 64'd1 : 64'd0);
      check("jf_addr", 64'(bus.instr_addr), (k == 0) ? 64'd5 : 64'd4);
    end

    // Shifts: 3>>1, then 1<<7, then 0x80<<1.
    do_reset();
    clear_mem();
    mem[0] = ins(OP_CLR, 0);
    mem[1] = ins(OP_LDA, 0);
    mem[2] = ins(OP_ADDA, 0);
    mem[3] = ins(OP_SHR, 0);
    for (int i = 5; i < 12; i++) mem[i] = ins(OP_SHL, 0);
    mem[13] = ins(OP_SHL, 0);
    bus.sw_a = 4'd3;
    pulse_start();
    wait_halted("shr");
    check("shr_acc", 64'(bus.acc), 64'h01);
    check("shr_flag", 64'(bus.flag), 64'd1);
    pulse_start();
    wait_halted("shl7");
    check("shl7_acc", 64'(bus.acc), 64'h80);
    check("shl7_flag", 64'(bus.flag), 64'd0);
    pulse_start();
    wait_halted("shl");
    check("shl_acc", 64'(bus.acc), 64'h00);
    check("shl_flag", 64'(bus.flag), 64'd1);

    // Multiply (or NOP when the multiplier is not built).
    do_reset();
    clear_mem();
    mem[0] = ins(OP_LDA, 0);
    mem[1] = ins(OP_LDB, 0);
    mem[2] = ins(OP_SUBB, 0);
    mem[3] = ins(OP_MUL, 0);
    bus.sw_a = 4'hF;
    bus.sw_b = 4'hF;
    pulse_start();
    wait_halted("mul");
`ifdef PARAM_MICRO_CORE_MUL_EN
    check("mul_acc", 64'(bus.acc), 64'hE1);
`else
    check("mul_acc", 64'(bus.acc), 64'hF1);
`endif
    check("mul_flag", 64'(bus.flag), 64'd1);
    check("mul_pc", 64'(bus.pc), 64'd5);

    // Reset while waiting on the output handshake.
    do_reset();
    load_sum_prog();
    bus.sw_a = 4'd9;
    bus.sw_b = 4'd3;
    bus.out_ready = 1'b0;
    pulse_start();
    wait_valid("rst_ow");
    do_reset();
    check_zero("rst_outwait");

    // Reset landing on the EXEC edge of ADDA.
    bus.out_ready = 1'b1;
    pulse_start();
    begin
      int n = 0;
      while (!(m_cnt == 2 && m_ir[IW-1 -: 4] == OP_ADDA) && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        checks++; errors++;
        $display("FAIL adda_timeout actual=none required=ADDA decode");
      end
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_zero("rst_exec");
    pulse_start();
    @(negedge clk);
    check("restart_addr", 64'(bus.instr_addr), 64'd0);
    @(negedge clk);
    check("restart_ir", 64'(bus.ir), 64'h020);
    wait_halted("restart");
    check("restart_pc", 64'(bus.pc), 64'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_micro_core.md
# param_micro_core

Parametrised successor to the fixed 4-bit microcontroller top level. It merges the control FSM, instruction sequencing and datapath into one core. It adds:
- configurable operand and program-counter widths,
- an external synchronous instruction-memory port,
- conditional branching on the flag,
- a halt/start control,
- a valid/ready handshake on the output register.

It sits between the board switches or an upstream stimulus block and the display or output logic.

## Interface
- DATA_W, 4, operand width of reg_a/reg_b; ACC_W = 2*DATA_W
- PC_W, 5, program counter width; program depth = 2**PC_W; instruction width IW = 4+PC_W
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low; sampled on clk rising edge
- start  in  1  leave HALT and begin or resume fetching
- sw_a  in  DATA_W  external input loaded by LDA
- sw_b  in  DATA_W  external input loaded by LDB
- instr_addr  out  PC_W  instruction memory address (registered)
- instr_data  in  IW  instruction word, valid 1 cycle after instr_addr
- out_data  out  ACC_W  output register
- out_valid  out  1  out_data holds a new result
- out_ready  in  1  consumer accepts out_data
- reg_a, reg_b  out  DATA_W  operand registers
- acc  out  ACC_W  accumulator
- flag  out  1  carry/borrow/shifted-out bit
- pc  out  PC_W  program counter
- ir  out  IW  instruction register
- halted  out  1  core in HALT

## Operation
- Instruction format: [IW-1:PC_W] opcode; [PC_W-1:0] branch target, ignored by non-branch ops.
- Opcodes:
  - 0 NOP
  - 1 LDA: reg_a<=sw_a
  - 2 LDB: reg_b<=sw_b
  - 3 CLR: acc<=0, flag<=0
  - 4 ADDA / 5 ADDB: acc<=acc+zext(reg) mod 2^ACC_W, flag<=carry
  - 6 SUBA / 7 SUBB: acc<=acc-zext(reg), flag<=borrow
  - 8 SHL: acc<<1, flag<=old msb
  - 9 SHR: acc>>1 logical, flag<=old lsb
  - A AND: acc<=zext(reg_a&reg_b)
  - B MUL: acc<=reg_a*reg_b, unsigned and exact
  - C OUT
  - D JMP: pc<=target
  - E JF: pc<=target if flag, else pc+1
  - F HLT
- Ops not listed as writing flag leave it unchanged.
- FSM states HALT, FETCH, DECODE, EXEC, OUTWAIT:
  - HALT: stay until start=1, then go to FETCH.
  - FETCH: instr_addr<=pc, then go to DECODE.
  - DECODE: ir<=instr_data, then go to EXEC.
  - EXEC: perform the op and go to FETCH. OUT instead loads out_data<=acc, sets out_valid<=1 and goes to OUTWAIT. HLT goes to HALT.
  - OUTWAIT: when out_ready=1, clear out_valid and go to FETCH.
- pc update in EXEC: pc+1, wrapping modulo 2**PC_W, for every op except a taken JMP/JF. HLT also increments, so start resumes at the following instruction.
- start is ignored outside HALT.
- out_data only changes in EXEC of OUT, so it is stable while out_valid=1.

## Timing
- Reset values: state HALT, halted=1, and every other output 0: pc, ir, instr_addr, reg_a, reg_b, acc, flag, out_data, out_valid.
- Reset overrides everything in any state, including mid-OUTWAIT; out_valid drops at the reset edge.
- Cycle counts:
  - 3 cycles per instruction (FETCH, DECODE, EXEC).
  - OUT takes 3 cycles plus the OUTWAIT cycles; minimum 4 when out_ready is already high.
  - start seen at edge N: FETCH at N+1 and the first EXEC at N+3.
- Handshake transfer happens on the edge where out_valid and out_ready are both high. out_ready while out_valid=0 is ignored.
- Register results are visible the cycle after EXEC. A following instruction's EXEC always sees them, so there are no hazards.

## Configuration
- PARAM_MICRO_CORE_MUL_EN defined: opcode B is MUL, implemented as a DATA_W×DATA_W multiplier.
- Not defined: no multiplier is synthesised. Opcode B executes as NOP (acc and flag unchanged, pc+1).

## Structure
- Package param_micro_core_pkg holds the opcode localparams (OP_NOP … OP_HLT), the FSM state typedef and the function computing the opcode field position.
- One sub-module, param_micro_core_alu: combinational adder/subtractor, shifter, AND and optional multiplier. It returns the next acc and next flag for a given opcode.
- The top holds the FSM, pc, ir, registers and the handshake.

## Test plan
- Defaults. Program LDA, LDB, ADDA, ADDB, OUT, HLT with sw_a=9, sw_b=3; pulse start.
  - Expect out_valid with out_data=8'h0C and flag=0.
  - After the handshake: halted=1, pc=6.
- CLR, LDB (sw_b=1), SUBB, JF 5 → acc=8'hFF, flag=1, next instr_addr=5.
  - Same sequence with sw_b=0 → flag=0, JF not taken, instr_addr=4.
- acc=8'h03, SHR → acc=8'h01, flag=1. Then acc=8'h80, SHL → acc=8'h00, flag=1.
- LDA/LDB F, F, then MUL:
  - With the macro: acc=8'hE1.
  - Without it: acc and flag unchanged, pc increments.
- OUT with out_ready low for 5 cycles → out_valid held, out_data stable, instr_addr frozen. Raise out_ready → out_valid drops next edge and FETCH resumes.
- reset low during OUTWAIT and again during EXEC of ADDA → next edge all outputs zero, halted=1. start then fetches from address 0.
